// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate-bank vector checker: FSM state encoding,
// dut_out bit positions, the expected-result table and SETTLE_CYCLES limits.
package gate_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   // Bit positions inside dut_out
   localparam logic [2:0] BIT_AND   = 3'd0;
   localparam logic [2:0] BIT_OR    = 3'd1;
   localparam logic [2:0] BIT_NOT_A = 3'd2;
   localparam logic [2:0] BIT_NAND  = 3'd3;
   localparam logic [2:0] BIT_NOR   = 3'd4;
   localparam logic [2:0] BIT_XOR   = 3'd5;
   localparam logic [2:0] BIT_XNOR  = 3'd6;

   // Legal range of the DRIVE hold time
   localparam int unsigned SETTLE_MIN = 1;
   localparam int unsigned SETTLE_MAX = 15;

   // Ideal gate-bank response for one {a,b} input pair
   function automatic logic [6:0] gate_ideal(input logic [1:0] ab);
      logic [6:0] r;
      r            = '0;
      r[BIT_AND]   = ab[1] & ab[0];
      r[BIT_OR]    = ab[1] | ab[0];
      r[BIT_NOT_A] = ~ab[1];
      r[BIT_NAND]  = ~(ab[1] & ab[0]);
      r[BIT_NOR]   = ~(ab[1] | ab[0]);
      r[BIT_XOR]   = ab[1] ^ ab[0];
      r[BIT_XNOR]  = ~(ab[1] ^ ab[0]);
      return r;
   endfunction

   // Expected table indexed by {a,b}: 00 -> 5C, 01 -> 2E, 10 -> 2A, 11 -> 43
   localparam logic [3:0][6:0] EXP_TABLE = {
      gate_ideal(2'b11), gate_ideal(2'b10), gate_ideal(2'b01), gate_ideal(2'b00)
   };

   // Keeps an out-of-range SETTLE_CYCLES inside the counter's reach
   function automatic int unsigned settle_clamp(input int unsigned n);
      if (n < SETTLE_MIN) return SETTLE_MIN;
      if (n > SETTLE_MAX) return SETTLE_MAX;
      return n;
   endfunction

endpackage

// File: rtl/gate_vector_checker_settle.sv
// gate_settle_timer: down-counter holding each input vector for SETTLE_CYCLES
// cycles. load restarts the hold, count steps it, expire flags the last cycle.
module gate_settle_timer
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam logic [3:0] LOAD_VAL = 4'(settle_clamp(SETTLE_CYCLES) - 1);

   logic [3:0] cnt;

   // Hold counter: reload on entry to DRIVE, step down while holding
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: drives the four {a,b} vectors into a 7-output gate
// bank, compares each settled response against EXP_TABLE and reports
// pass / fail_mask at the end of the pass.
// Optional macro GATE_CHECK_ERRLOG_EN adds err_valid / err_vec, which log the
// first mismatching vector of a pass.
module gate_vector_checker
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a_drv,
   output logic       b_drv,
   input  logic [6:0] dut_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] fail_mask
`ifdef GATE_CHECK_ERRLOG_EN
   ,
   output logic       err_valid,
   output logic [1:0] err_vec
`endif
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] vec;
   logic [6:0] mismatch;
   logic       tmr_load;
   logic       tmr_count;
   logic       tmr_expire;

   gate_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load),
      .count  (tmr_count),
      .expire (tmr_expire)
   );

   assign mismatch = dut_out ^ EXP_TABLE[vec];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode, timer control and Moore outputs
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_count = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      a_drv     = 1'b0;
      b_drv     = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = ST_DRIVE;
               tmr_load  = 1'b1;
            end
         end
         ST_DRIVE: begin
            {a_drv, b_drv} = vec;
            if (tmr_expire) begin
               state_nxt = ST_SAMPLE;
            end else begin
               tmr_count = 1'b1;
            end
         end
         ST_SAMPLE: begin
            {a_drv, b_drv} = vec;
            if (vec == 2'd3) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_DRIVE;
               tmr_load  = 1'b1;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Vector index, mismatch accumulation and pass verdict
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec       <= '0;
         fail_mask <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  vec       <= '0;
                  fail_mask <= '0;
                  pass      <= 1'b0;
               end
            end
            ST_SAMPLE: begin
               fail_mask <= fail_mask | mismatch;
               if (vec != 2'd3) begin
                  vec <= vec + 2'd1;
               end
            end
            ST_DONE: begin
               pass <= (fail_mask == '0);
            end
            default: ;
         endcase
      end
   end

`ifdef GATE_CHECK_ERRLOG_EN
   // First-mismatch log: cleared on start acceptance, written once per pass
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err_vec   <= '0;
      end else if ((state == ST_IDLE) && start) begin
         err_valid <= 1'b0;
         err_vec   <= '0;
      end else if ((state == ST_SAMPLE) && !err_valid && (mismatch != '0)) begin
         err_valid <= 1'b1;
         err_vec   <= vec;
      end
   end
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three instances (SETTLE_CYCLES 2, 1, 15),
// each driven by a behavioural gate bank with selectable fault. Expected
// pass results are queued at start and compared when done pulses.
// Build with GATE_CHECK_ERRLOG_EN defined to also check err_valid / err_vec.
`timescale 1ns/1ps
module tb_gate_vector_checker;

   localparam int N = 3;

   function automatic int sc_of(input int g);
      return (g == 0) ? 2 : (g == 1) ? 1 : 15;
   endfunction

   logic       clk = 1'b0;
   logic       rst_n     [N];
   logic       start     [N];
   logic       a_drv     [N];
   logic       b_drv     [N];
   logic       busy      [N];
   logic       done      [N];
   logic       pass      [N];
   logic [6:0] fail_mask [N];
   logic [6:0] dut_out   [N];
   int         fault     [N];
`ifdef GATE_CHECK_ERRLOG_EN
   logic       err_valid [N];
   logic [1:0] err_vec   [N];
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         done_at;
      logic [6:0] mask;
      logic       pss;
      logic       ev;
      logic [1:0] evec;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Ideal gates, order {xnor, xor, nor, nand, not a, or, and}
   function automatic logic [6:0] ideal(input logic a, input logic b);
      return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
   endfunction

   // fault 1: and stuck at 0; fault 2: not(a) inverted
   function automatic logic [6:0] bank(input logic a, input logic b, input int f);
      logic [6:0] r;
      r = ideal(a, b);
      if (f == 1) r[0] = 1'b0;
      if (f == 2) r[2] = ~r[2];
      return r;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      assign dut_out[g] = bank(a_drv[g], b_drv[g], fault[g]);
      gate_vector_checker #(
         .SETTLE_CYCLES (sc_of(g))
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n[g]),
         .start     (start[g]),
         .a_drv     (a_drv[g]),
         .b_drv     (b_drv[g]),
         .dut_out   (dut_out[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .pass      (pass[g]),
         .fail_mask (fail_mask[g])
`ifdef GATE_CHECK_ERRLOG_EN
         ,
         .err_valid (err_valid[g]),
         .err_vec   (err_vec[g])
`endif
      );
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Queue the expected outcome of one pass ending at window cycle done_at
   task automatic push_pass(input int done_at, input int f);
      exp_t       e;
      logic [6:0] d;
      logic [1:0] ab;
      e.done_at = done_at;
      e.mask    = '0;
      e.ev      = 1'b0;
      e.evec    = '0;
      for (int v = 0; v < 4; v++) begin
         ab = 2'(v);
         d  = bank(ab[1], ab[0], f) ^ ideal(ab[1], ab[0]);
         e.mask |= d;
         if ((d != '0) && !e.ev) begin
            e.ev   = 1'b1;
            e.evec = ab;
         end
      end
      e.pss = (e.mask == '0);
      sb.push_back(e);
   endtask

   // Raise start, hold it for 'hold' cycles, observe 'cycles' cycles.
   // Cycle c is sampled on the c-th falling edge after the accepting edge.
   task automatic run_window(input int i, input int hold, input int cycles,
                             input int exp_dones, input bit chk_seq);
      int   ndone;
      bit   pend;
      exp_t cur;
      int   s;
      ndone = 0;
      pend  = 1'b0;
      s     = sc_of(i);
      cur   = '{default: '0};
      start[i] = 1'b1;
      for (int c = 1; c <= cycles; c++) begin
         @(negedge clk);
         if (c == hold) start[i] = 1'b0;
         if (pend) begin
            check_val("pass_after_done", pass[i], cur.pss);
            check_val("busy_after_done", busy[i], 1'b0);
            pend = 1'b0;
         end
         if (chk_seq && (c < 4 * (s + 1) + 1)) begin
            check_val("ab_seq", {a_drv[i], b_drv[i]}, 32'((c - 1) / (s + 1)));
            check_val("busy_run", busy[i], 1'b1);
         end
         if (done[i]) begin
            ndone++;
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               check_val("done_latency", c, cur.done_at);
               check_val("fail_mask", fail_mask[i], cur.mask);
               check_val("ab_in_done", {a_drv[i], b_drv[i]}, 2'b00);
               check_val("busy_in_done", busy[i], 1'b1);
`ifdef GATE_CHECK_ERRLOG_EN
               check_val("err_valid", err_valid[i], cur.ev);
               check_val("err_vec", err_vec[i], cur.evec);
`endif
               pend = 1'b1;
            end
         end
      end
      start[i] = 1'b0;
      check_val("done_count", ndone, exp_dones);
      check_val("sb_left", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rst_n[i] = 1'b0;
         start[i] = 1'b0;
         fault[i] = 0;
      end
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy[0], 1'b0);
      check_val("rst_done", done[0], 1'b0);
      check_val("rst_pass", pass[0], 1'b0);
      check_val("rst_mask", fail_mask[0], 7'h00);
      check_val("rst_ab", {a_drv[0], b_drv[0]}, 2'b00);
      for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
      @(negedge clk);

      // Ideal bank, default settle time
      push_pass(13, 0);
      run_window(0, 1, 16, 1, 1'b1);

      // and output stuck at 0, then results must hold while idle
      fault[0] = 1;
      push_pass(13, 1);
      run_window(0, 1, 16, 1, 1'b1);
      repeat (5) @(negedge clk);
      check_val("hold_mask", fail_mask[0], 7'h01);
      check_val("hold_pass", pass[0], 1'b0);

      // not output inverted on every vector
      fault[0] = 2;
      push_pass(13, 2);
      run_window(0, 1, 16, 1, 1'b1);
      repeat (3) @(negedge clk);
      check_val("hold_mask_not", fail_mask[0], 7'h04);
`ifdef GATE_CHECK_ERRLOG_EN
      check_val("hold_err_vec", err_vec[0], 2'b00);
`endif
      fault[0] = 0;

      // start held 20 cycles: one pass, then one more right after DONE
      push_pass(13, 0);
      push_pass(27, 0);
      run_window(0, 20, 34, 2, 1'b0);

      // Reset during the third vector's DRIVE aborts the pass silently
      fault[0] = 2;
      start[0] = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) start[0] = 1'b0;
      end
      check_val("pre_rst_ab", {a_drv[0], b_drv[0]}, 2'b10);
      check_val("pre_rst_mask", fail_mask[0], 7'h04);
      rst_n[0] = 1'b0;
      @(negedge clk);
      check_val("abort_busy", busy[0], 1'b0);
      check_val("abort_done", done[0], 1'b0);
      check_val("abort_pass", pass[0], 1'b0);
      check_val("abort_mask", fail_mask[0], 7'h00);
      check_val("abort_ab", {a_drv[0], b_drv[0]}, 2'b00);
`ifdef GATE_CHECK_ERRLOG_EN
      check_val("abort_err_valid", err_valid[0], 1'b0);
`endif
      @(negedge clk);
      rst_n[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_val("no_done_after_abort", done[0], 1'b0);
      end
      fault[0] = 0;
      push_pass(13, 0);
      run_window(0, 1, 16, 1, 1'b1);

      // Settle-time extremes
      push_pass(9, 0);
      run_window(1, 1, 12, 1, 1'b1);
      push_pass(65, 0);
      run_window(2, 1, 68, 1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of cycles each input vector is held before sampling; legal 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request one full check pass; accepted only in IDLE.
REQ-005 a_drv  output  1  drives gate-bank input a.
REQ-006 b_drv  output  1  drives gate-bank input b.
REQ-007 dut_out  input  7  gate-bank results, bit order [6:0] = {xnor, xor, nor, nand, not(a), or, and}.
REQ-008 busy  output  1  high from start acceptance until the DONE cycle inclusive.
REQ-009 done  output  1  one-cycle pulse at end of pass.
REQ-010 pass  output  1  high when the last completed pass had no mismatch.
REQ-011 fail_mask  output  7  OR-accumulated mismatch bits over all vectors of the current/last pass.

Function
REQ-012 FSM states shall be IDLE, DRIVE, SAMPLE, DONE.
REQ-013 IDLE with start=1 shall go to DRIVE, set vec=0, clear fail_mask, clear pass.
REQ-014 {a_drv, b_drv} shall equal vec[1:0] in DRIVE and SAMPLE, and 2'b00 in IDLE and DONE.
REQ-015 DRIVE shall last exactly SETTLE_CYCLES cycles, counted by a settle counter, then go to SAMPLE.
REQ-016 SAMPLE shall last one cycle: fail_mask <= fail_mask | (dut_out ^ EXP[vec]).
REQ-017 From SAMPLE: vec==3 goes to DONE; otherwise vec increments and returns to DRIVE.
REQ-018 Expected table EXP, indexed by {a,b}: 00 -> 7'h5C, 01 -> 7'h2E, 10 -> 7'h2A, 11 -> 7'h43.
REQ-019 In DONE, done=1 for one cycle, and pass <= (final fail_mask == 0), including the last SAMPLE's contribution; next state is IDLE.
REQ-020 Latency: done shall assert exactly 4*(SETTLE_CYCLES+1)+1 cycles after the edge that accepted start (13 for the default).
REQ-021 start while busy, including the DONE cycle, shall be ignored and shall not be queued.
REQ-022 pass and fail_mask shall hold their values in IDLE until the next accepted start.
REQ-023 vec shall not wrap; a pass covers exactly four vectors, in order 0, 1, 2, 3.

Reset
REQ-024 rst_n=0 at a clock edge shall force IDLE, vec=0, settle counter=0, a_drv=0, b_drv=0, busy=0, done=0, pass=0, fail_mask=0.
REQ-025 Reset asserted mid-pass shall abort the pass with no done pulse; the first start after release begins a fresh pass.

Configuration
REQ-026 Macro GATE_CHECK_ERRLOG_EN, when defined, shall add outputs err_valid (1) and err_vec (2).
REQ-027 With the macro defined, err_valid and err_vec shall capture the first mismatching vector of a pass; later mismatches shall not overwrite them.
REQ-028 With the macro defined, err_valid and err_vec shall clear on start acceptance and on reset.
REQ-029 Without the macro, the err_* ports and their logic shall be absent, and all other behaviour shall be unchanged.

Structure
REQ-030 Shared package gate_check_pkg shall hold the state enum, the dut_out bit-index constants, the EXP table, and the SETTLE_CYCLES range limits.
REQ-031 One sub-module, gate_settle_timer (load/count/expire), shall implement the DRIVE hold counter.

Verification
REQ-032 Ideal gate-bank model, SETTLE_CYCLES=2, start pulse -> done 13 cycles later, pass=1, fail_mask=7'h00, a/b sequence 00,01,10,11.
REQ-033 Model with the and output stuck at 0 -> pass=0, fail_mask=7'h01; with the macro defined, err_valid=1 and err_vec=2'b11.
REQ-034 Model with not output inverted -> fail_mask=7'h04; with the macro defined, err_vec=2'b00 and it stays 00.
REQ-035 start held high for 20 cycles -> exactly one pass accepted during busy, then a second pass starts the cycle after DONE returns to IDLE.
REQ-036 rst_n low during the third vector's DRIVE -> no done pulse, all outputs zero; next start -> full clean pass, pass=1.
REQ-037 SETTLE_CYCLES=1 and SETTLE_CYCLES=15 -> done latency of 9 and 65 cycles respectively.
